core_cp_access_ctrl: RTL and testbench
======================================

Name: core_cp_access_ctrl

Overview:
- Control-plane access sequencer that sits directly upstream of the per-core parameter/state tables (the DSID/state table and its siblings).
- Accepts single read or write requests on a valid/ready channel and decodes the table index into a one-hot table select.
- Drives col/row/wdata and a single-cycle wen, samples the selected table's combinational rdata once it has settled, and returns a response on a valid/ready channel.
- Keeps saturating read/write/error access counters for debug.

Parameters:
- N_TABLES, 4, number of attached tables; one select bit and one 64-bit rdata slice per table.
- TAB_W, 2, width of the request table index; values >= N_TABLES are invalid.
- CNT_W, 32, width of each access counter.

Ports:
- SYS_CLK  in  1  clock
- DETECT_RST  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_wr  in  1  1 = write, 0 = read
- req_table  in  TAB_W  target table index
- req_col  in  15  column
- req_row  in  15  row
- req_wdata  in  64  write data
- tab_sel  out  N_TABLES  one-hot table select; feeds each table's is_this_table
- tab_col  out  15  column to tables
- tab_row  out  15  row to tables
- tab_wdata  out  64  write data to tables
- tab_wen  out  1  write strobe, one cycle
- tab_rdata  in  64*N_TABLES  flat concatenation; slice i = table i rdata (combinational in col/row)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  64  read data, or post-write readback
- resp_err  out  1  invalid table index
- cnt_rd  out  CNT_W  completed valid reads
- cnt_wr  out  CNT_W  completed valid writes
- cnt_err  out  CNT_W  invalid-index requests

Behaviour:
- FSM states: IDLE, ACCESS, CAPTURE, RESP. All state and outputs are registered.
- IDLE:
  - req_ready=1; all other outputs are idle values.
  - On req_valid&req_ready: latch wr/table/col/row/wdata, set err = (req_table >= N_TABLES), go to ACCESS.
- ACCESS (1 cycle):
  - tab_col/tab_row/tab_wdata drive the latched values.
  - tab_sel = one-hot(table) if !err, else 0.
  - tab_wen = wr & !err.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - col/row/sel held; tab_wen=0.
  - resp_rdata <= err ? 0 : tab_rdata slice[table]. For writes this is the value after the write (table registers updated at the end of ACCESS).
  - resp_err <= err.
  - Increment exactly one counter: cnt_err if err, else cnt_wr if wr, else cnt_rd.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable.
  - On resp_ready go to IDLE; resp_valid drops the next cycle.
- Latency:
  - Request accepted at edge T.
  - tab_wen high in cycle T+1.
  - Capture at edge T+2.
  - resp_valid high from cycle T+2 until the handshake.
  - Minimum request-to-request spacing is 4 cycles with resp_ready tied high.
- Only one outstanding request. req_ready=0 in every state except IDLE. No request is accepted in the same cycle as a response handshake.
- tab_col/tab_row/tab_wdata hold their last values outside ACCESS/CAPTURE. tab_sel=0 and tab_wen=0 outside ACCESS/CAPTURE.
- Counters saturate at all-ones and do not wrap.
- Reset values:
  - state=IDLE; req_ready=1 after reset deassertion.
  - tab_sel=0, tab_wen=0, tab_col=0, tab_row=0, tab_wdata=0.
  - resp_valid=0, resp_rdata=0, resp_err=0, all counters=0.
- Reset mid-operation:
  - DETECT_RST asserted in any state returns immediately to IDLE.
  - A pending response is discarded; an in-flight wen is cut. The table itself is also reset by DETECT_RST.
  - Counters clear.
- resp_ready held high while in IDLE has no effect.
- req fields may change while req_ready=0; only the values sampled at the handshake are used.

Decomposition:
- Shared package core_cp_pkg:
  - FSM state encoding.
  - Column/row width constant (15).
  - Data width constant (64).
  - Column indices for existing tables (COL_DSID=0, COL_STATE=1).
- Sub-module core_cp_sat_counter (CNT_W, inc, saturating, async reset). Instantiated three times.

Test Plan:
- Reset, then write table0 col0 row2 wdata 0x0000_0000_0000_ABCD with resp_ready=1:
  - tab_wen high exactly 1 cycle with tab_sel=4'b0001, row=2.
  - resp_rdata=0xABCD, resp_err=0, cnt_wr=1.
- Read table0 col1 row3 with stub rdata slice0=0x1 and other slices=0xDEAD:
  - tab_wen never high.
  - resp_rdata=0x1, cnt_rd=1.
- Request with req_table=5 (TAB_W=3, N_TABLES=4):
  - tab_sel=0, tab_wen=0 throughout.
  - resp_err=1, resp_rdata=0, cnt_err=1; cnt_rd and cnt_wr unchanged.
- Hold resp_ready=0 for 10 cycles after resp_valid:
  - resp_valid and resp_rdata stable, req_ready=0.
  - A second req_valid is not accepted until 1 cycle after the handshake.
- Assert DETECT_RST during ACCESS of a write:
  - tab_wen=0 and resp_valid=0 immediately, all counters=0.
  - req_ready=1 after reset release.
- Preload cnt_rd to all-ones (CNT_W=4 build), issue one read:
  - cnt_rd stays 4'hF.

Source files
------------

// File: rtl/core_cp_pkg.sv
// Shared definitions for the control-plane table access path.
package core_cp_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } cp_state_e;

  // Column/row address width into the per-core tables.
  localparam int CP_CR_W = 15;

  // Table data width.
  localparam int CP_DATA_W = 64;

  // Column indices of the existing per-core tables.
  localparam int COL_DSID  = 0;
  localparam int COL_STATE = 1;

endpackage

// File: rtl/core_cp_access_ctrl_sat_counter.sv
// Saturating up-counter used for the debug access statistics.
module core_cp_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             SYS_CLK,
  input  logic             DETECT_RST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step by one unless already pinned at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/core_cp_access_ctrl.sv
// Control-plane access sequencer in front of the per-core parameter/state
// tables. One request at a time: decode, strobe, capture, respond.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | ready for a request; table bus idle
//   ST_ACCESS  | col/row/wdata/sel driven, wen pulsed for valid writes
//   ST_CAPTURE | bus held while table rdata settles; sampled at exit
//   ST_RESP    | response presented until the consumer takes it
module core_cp_access_ctrl
  import core_cp_pkg::*;
#(
  parameter int N_TABLES = 4,
  parameter int TAB_W    = 2,
  parameter int CNT_W    = 32
) (
  input  logic                          SYS_CLK,
  input  logic                          DETECT_RST,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_wr,
  input  logic [TAB_W-1:0]              req_table,
  input  logic [CP_CR_W-1:0]            req_col,
  input  logic [CP_CR_W-1:0]            req_row,
  input  logic [CP_DATA_W-1:0]          req_wdata,
  output logic [N_TABLES-1:0]           tab_sel,
  output logic [CP_CR_W-1:0]            tab_col,
  output logic [CP_CR_W-1:0]            tab_row,
  output logic [CP_DATA_W-1:0]          tab_wdata,
  output logic                          tab_wen,
  input  logic [CP_DATA_W*N_TABLES-1:0] tab_rdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [CP_DATA_W-1:0]          resp_rdata,
  output logic                          resp_err,
  output logic [CNT_W-1:0]              cnt_rd,
  output logic [CNT_W-1:0]              cnt_wr,
  output logic [CNT_W-1:0]              cnt_err
);

  cp_state_e            state_q, state_d;
  logic                 wr_q, wr_d;
  logic [TAB_W-1:0]     table_q, table_d;
  logic                 err_q, err_d;
  logic                 req_ready_q, req_ready_d;
  logic [N_TABLES-1:0]  tab_sel_q, tab_sel_d;
  logic [CP_CR_W-1:0]   tab_col_q, tab_col_d;
  logic [CP_CR_W-1:0]   tab_row_q, tab_row_d;
  logic [CP_DATA_W-1:0] tab_wdata_q, tab_wdata_d;
  logic                 tab_wen_q, tab_wen_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [CP_DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;

  logic                 req_err;
  logic [N_TABLES-1:0]  req_sel;
  logic [CP_DATA_W-1:0] rdata_sel;
  logic                 inc_rd, inc_wr, inc_err;

  assign req_err = (32'(req_table) >= 32'(N_TABLES));

  // One-hot decode of the incoming table index; all-zero when out of range.
  always_comb begin
    req_sel = '0;
    for (int i = 0; i < N_TABLES; i++) begin
      if (32'(req_table) == 32'(i)) begin
        req_sel[i] = 1'b1;
      end
    end
  end

  // Pick the latched table's rdata slice out of the flat bus.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < N_TABLES; i++) begin
      if (32'(table_q) == 32'(i)) begin
        rdata_sel = tab_rdata[i*CP_DATA_W +: CP_DATA_W];
      end
    end
  end

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    table_d      = table_q;
    err_d        = err_q;
    req_ready_d  = req_ready_q;
    tab_sel_d    = tab_sel_q;
    tab_col_d    = tab_col_q;
    tab_row_d    = tab_row_q;
    tab_wdata_d  = tab_wdata_q;
    tab_wen_d    = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    inc_rd       = 1'b0;
    inc_wr       = 1'b0;
    inc_err      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          // Outputs are registered, so the ACCESS-cycle bus values are
          // loaded straight from the request at the accepting edge.
          wr_d        = req_wr;
          table_d     = req_table;
          err_d       = req_err;
          tab_col_d   = req_col;
          tab_row_d   = req_row;
          tab_wdata_d = req_wdata;
          tab_sel_d   = req_err ? '0 : req_sel;
          tab_wen_d   = req_wr & ~req_err;
          req_ready_d = 1'b0;
          state_d     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        // Table registers took the write at the end of ACCESS, so a write
        // captures its own post-write readback here.
        resp_rdata_d = err_q ? '0 : rdata_sel;
        resp_err_d   = err_q;
        resp_valid_d = 1'b1;
        tab_sel_d    = '0;
        inc_err      = err_q;
        inc_wr       = ~err_q & wr_q;
        inc_rd       = ~err_q & ~wr_q;
        state_d      = ST_RESP;
      end

      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        tab_sel_d   = '0;
      end
    endcase
  end

  // State and output registers; reset returns to an idle, empty sequencer.
  always_ff @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      state_q      <= ST_IDLE;
      wr_q         <= 1'b0;
      table_q      <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      tab_sel_q    <= '0;
      tab_col_q    <= '0;
      tab_row_q    <= '0;
      tab_wdata_q  <= '0;
      tab_wen_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      table_q      <= table_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      tab_sel_q    <= tab_sel_d;
      tab_col_q    <= tab_col_d;
      tab_row_q    <= tab_row_d;
      tab_wdata_q  <= tab_wdata_d;
      tab_wen_q    <= tab_wen_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign tab_sel    = tab_sel_q;
  assign tab_col    = tab_col_q;
  assign tab_row    = tab_row_q;
  assign tab_wdata  = tab_wdata_q;
  assign tab_wen    = tab_wen_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  core_cp_sat_counter #(.CNT_W(CNT_W)) u_cnt_rd (
    .SYS_CLK    (SYS_CLK),
    .DETECT_RST (DETECT_RST),
    .inc        (inc_rd),
    .cnt        (cnt_rd)
  );

  core_cp_sat_counter #(.CNT_W(CNT_W)) u_cnt_wr (
    .SYS_CLK    (SYS_CLK),
    .DETECT_RST (DETECT_RST),
    .inc        (inc_wr),
    .cnt        (cnt_wr)
  );

  core_cp_sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
    .SYS_CLK    (SYS_CLK),
    .DETECT_RST (DETECT_RST),
    .inc        (inc_err),
    .cnt        (cnt_err)
  );

endmodule

// File: tb/tb_core_cp_access_ctrl.sv
// Bench for core_cp_access_ctrl with a small register-file table stub.
module tb_core_cp_access_ctrl;
  import core_cp_pkg::*;

  localparam int NT = 4;
  localparam int TW = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              SYS_CLK = 1'b0;
  logic              DETECT_RST;
  logic              req_valid, req_ready, req_wr;
  logic [TW-1:0]     req_table;
  logic [14:0]       req_col, req_row;
  logic [63:0]       req_wdata;
  logic [NT-1:0]     tab_sel;
  logic [14:0]       tab_col, tab_row;
  logic [63:0]       tab_wdata;
  logic              tab_wen;
  logic [64*NT-1:0]  tab_rdata;
  logic              resp_valid, resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic [CW-1:0]     cnt_rd, cnt_wr, cnt_err;

  int errors = 0;
  int checks = 0;

  logic [63:0] stub_mem [NT][64];
  logic        force_en = 1'b0;

  logic [63:0] exp_mem [NT][64];
  int m_rd, m_wr, m_err;

  core_cp_access_ctrl #(.N_TABLES(NT), .TAB_W(TW), .CNT_W(CW)) dut (
    .SYS_CLK(SYS_CLK), .DETECT_RST(DETECT_RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_table(req_table), .req_col(req_col), .req_row(req_row), .req_wdata(req_wdata),
    .tab_sel(tab_sel), .tab_col(tab_col), .tab_row(tab_row), .tab_wdata(tab_wdata),
    .tab_wen(tab_wen), .tab_rdata(tab_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr), .cnt_err(cnt_err)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Table stub: combinational read, write on the strobe, cleared by reset.
  always @(posedge SYS_CLK or posedge DETECT_RST) begin
    if (DETECT_RST) begin
      for (int t = 0; t < NT; t++)
        for (int a = 0; a < 64; a++) stub_mem[t][a] <= '0;
    end else if (tab_wen) begin
      for (int t = 0; t < NT; t++)
        if (tab_sel[t]) stub_mem[t][{tab_col[1:0], tab_row[3:0]}] <= tab_wdata;
    end
  end

  always_comb begin
    tab_rdata = '0;
    for (int t = 0; t < NT; t++) begin
      if (force_en) tab_rdata[t*64 +: 64] = (t == 0) ? 64'h1 : 64'hDEAD;
      else          tab_rdata[t*64 +: 64] = stub_mem[t][{tab_col[1:0], tab_row[3:0]}];
    end
  end

  function automatic int adr(input logic [14:0] c, input logic [14:0] r);
    return int'(c[1:0]) * 16 + int'(r[3:0]);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < 64; a++) exp_mem[t][a] = '0;
    m_rd = 0; m_wr = 0; m_err = 0;
  endtask

  // Expected outcome of one transaction from the access rules.
  task automatic model_txn(input logic wr, input logic [TW-1:0] tbl, input logic [14:0] col,
                           input logic [14:0] row, input logic [63:0] wd,
                           output logic [63:0] e_rd, output logic e_err);
    e_err = (int'(tbl) >= NT);
    if (e_err) begin
      e_rd = '0; m_err = sat_inc(m_err);
    end else if (wr) begin
      exp_mem[tbl][adr(col, row)] = wd; e_rd = wd; m_wr = sat_inc(m_wr);
    end else begin
      e_rd = exp_mem[tbl][adr(col, row)]; m_rd = sat_inc(m_rd);
    end
  endtask

  // Drives one request and observes the table bus and response; called at a negedge.
  task automatic run_txn(input logic wr, input logic [TW-1:0] tbl, input logic [14:0] col,
                         input logic [14:0] row, input logic [63:0] wd, input int hold,
                         output logic [63:0] rd, output logic er, output int wen_cnt,
                         output int wen_at, output int lat, output logic [NT-1:0] sel_acc,
                         output logic [NT-1:0] sel_cap, output logic [NT-1:0] sel_resp,
                         output logic [14:0] row_acc, output logic stable);
    int n;
    wen_cnt = 0; wen_at = 0; lat = 0; stable = 1'b1;
    sel_acc = '0; sel_cap = '0; sel_resp = '0; row_acc = '0; rd = '0; er = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge SYS_CLK); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: req_ready=%0b required 1", req_ready);
    end
    resp_ready = (hold == 0);
    req_valid = 1'b1; req_wr = wr; req_table = tbl; req_col = col; req_row = row; req_wdata = wd;
    @(negedge SYS_CLK);
    req_valid = 1'b0; req_wr = 1'($urandom); req_table = TW'($urandom);
    req_col = 15'($urandom); req_row = 15'($urandom); req_wdata = {$urandom, $urandom};
    n = 1;
    while (!resp_valid && n < 20) begin
      if (tab_wen) begin wen_cnt++; wen_at = n; end
      if (n == 1) begin sel_acc = tab_sel; row_acc = tab_row; end
      if (n == 2) sel_cap = tab_sel;
      if (req_ready) stable = 1'b0;
      @(negedge SYS_CLK); n++;
    end
    lat = n;
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_wait: resp_valid=%0b required 1 within 20 cycles", resp_valid);
    end
    sel_resp = tab_sel;
    if (tab_wen) wen_cnt++;
    rd = resp_rdata; er = resp_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge SYS_CLK);
      if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready || tab_wen || tab_sel != '0)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge SYS_CLK);
    if (resp_valid || !req_ready) stable = 1'b0;
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    DETECT_RST = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_table = '0; req_col = '0; req_row = '0;
    req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    DETECT_RST = 1'b0;
    model_clear();
    @(negedge SYS_CLK);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1 || tab_sel !== '0 || tab_wen !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%0b sel=%b wen=%0b rvalid=%0b required 1 0000 0 0",
               req_ready, tab_sel, tab_wen, resp_valid);
    end
    checks++;
    if (tab_col !== '0 || tab_row !== '0 || tab_wdata !== '0 || resp_rdata !== '0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: col=%h row=%h wdata=%h rdata=%h err=%0b required all 0",
               tab_col, tab_row, tab_wdata, resp_rdata, resp_err);
    end
    checks++;
    if (cnt_rd !== '0 || cnt_wr !== '0 || cnt_err !== '0) begin
      errors++;
      $display("FAIL reset_cnt: rd=%0d wr=%0d err=%0d required 0 0 0", cnt_rd, cnt_wr, cnt_err);
    end
  endtask

  task automatic test_write();
    logic [63:0] rd, e_rd; logic er, e_er; int wc, wa, lat; logic [NT-1:0] sa, sc, sr;
    logic [14:0] ra; logic st;
    model_txn(1'b1, 3'd0, 15'd0, 15'd2, 64'hABCD, e_rd, e_er);
    run_txn(1'b1, 3'd0, 15'd0, 15'd2, 64'hABCD, 0, rd, er, wc, wa, lat, sa, sc, sr, ra, st);
    checks++;
    if (wc != 1 || wa != 1 || sa !== 4'b0001 || ra !== 15'd2) begin
      errors++;
      $display("FAIL write_strobe: wen_cycles=%0d at=%0d sel=%b row=%0d required 1 1 0001 2", wc, wa, sa, ra);
    end
    checks++;
    if (rd !== e_rd || er !== e_er || lat != 3) begin
      errors++;
      $display("FAIL write_resp: rdata=%h err=%0b lat=%0d required %h %0b 3", rd, er, lat, e_rd, e_er);
    end
    checks++;
    if (cnt_wr !== CW'(m_wr) || cnt_rd !== CW'(m_rd) || st !== 1'b1) begin
      errors++;
      $display("FAIL write_cnt: cnt_wr=%0d cnt_rd=%0d stable=%0b required %0d %0d 1", cnt_wr, cnt_rd, st, m_wr, m_rd);
    end
  endtask

  task automatic test_read();
    logic [63:0] rd; logic er; int wc, wa, lat; logic [NT-1:0] sa, sc, sr; logic [14:0] ra; logic st;
    force_en = 1'b1;
    m_rd = sat_inc(m_rd);
    run_txn(1'b0, 3'd0, 15'd1, 15'd3, 64'hFFFF, 0, rd, er, wc, wa, lat, sa, sc, sr, ra, st);
    force_en = 1'b0;
    checks++;
    if (wc != 0 || rd !== 64'h1 || er !== 1'b0) begin
      errors++;
      $display("FAIL read_stub: wen_cycles=%0d rdata=%h err=%0b required 0 1 0", wc, rd, er);
    end
    checks++;
    if (cnt_rd !== CW'(m_rd) || sa !== 4'b0001 || sc !== 4'b0001 || sr !== 4'b0000) begin
      errors++;
      $display("FAIL read_cnt_sel: cnt_rd=%0d sel=%b/%b/%b required %0d 0001/0001/0000", cnt_rd, sa, sc, sr, m_rd);
    end
  endtask

  task automatic test_invalid();
    logic [63:0] rd, e_rd; logic er, e_er; int wc, wa, lat; logic [NT-1:0] sa, sc, sr;
    logic [14:0] ra; logic st;
    model_txn(1'b1, 3'd5, 15'd0, 15'd2, 64'h5555, e_rd, e_er);
    run_txn(1'b1, 3'd5, 15'd0, 15'd2, 64'h5555, 0, rd, er, wc, wa, lat, sa, sc, sr, ra, st);
    checks++;
    if (wc != 0 || (sa | sc | sr) !== 4'b0000) begin
      errors++;
      $display("FAIL invalid_bus: wen_cycles=%0d sel=%b/%b/%b required 0 and all 0000", wc, sa, sc, sr);
    end
    checks++;
    if (er !== 1'b1 || rd !== 64'h0 || cnt_err !== CW'(m_err) || cnt_rd !== CW'(m_rd) || cnt_wr !== CW'(m_wr)) begin
      errors++;
      $display("FAIL invalid_resp: err=%0b rdata=%h cnt e/r/w=%0d/%0d/%0d required 1 0 %0d/%0d/%0d",
               er, rd, cnt_err, cnt_rd, cnt_wr, m_err, m_rd, m_wr);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e_rd, held; logic e_er; logic ok; int n;
    ok = 1'b1;
    resp_ready = 1'b0;
    model_txn(1'b1, 3'd1, 15'd2, 15'd5, 64'h1234_5678_9ABC_DEF0, e_rd, e_er);
    req_valid = 1'b1; req_wr = 1'b1; req_table = 3'd1; req_col = 15'd2; req_row = 15'd5;
    req_wdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge SYS_CLK);
    req_wr = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      if (req_ready) ok = 1'b0;
      @(negedge SYS_CLK); n++;
    end
    held = resp_rdata;
    for (int k = 0; k < 10; k++) begin
      if (!resp_valid || resp_rdata !== held || req_ready) ok = 1'b0;
      @(negedge SYS_CLK);
    end
    checks++;
    if (!ok || held !== e_rd) begin
      errors++;
      $display("FAIL bp_hold: stable=%0b rdata=%h required 1 %h", ok, held, e_rd);
    end
    resp_ready = 1'b1;
    @(negedge SYS_CLK);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake: resp_valid=%0b req_ready=%0b required 0 1", resp_valid, req_ready);
    end
    model_txn(1'b0, 3'd1, 15'd2, 15'd5, 64'h0, e_rd, e_er);
    @(negedge SYS_CLK);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge SYS_CLK); n++; end
    checks++;
    if (n != 2 || resp_rdata !== e_rd || cnt_rd !== CW'(m_rd) || cnt_wr !== CW'(m_wr)) begin
      errors++;
      $display("FAIL bp_second: wait=%0d rdata=%h rd/wr=%0d/%0d required 2 %h %0d/%0d",
               n, resp_rdata, cnt_rd, cnt_wr, e_rd, m_rd, m_wr);
    end
    @(negedge SYS_CLK);
    resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc[$]; logic ok; int n;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_table = 3'd2; req_col = 15'd3; req_row = 15'd7;
    for (int c = 0; c < 24; c++) begin
      if (c == 23) req_valid = 1'b0;
      else if (req_ready) acc.push_back(c);
      @(negedge SYS_CLK);
    end
    ok = (acc.size() == 6);
    for (int i = 1; i < acc.size(); i++) if (acc[i] - acc[i-1] != 4) ok = 1'b0;
    for (int i = 0; i < acc.size(); i++) m_rd = sat_inc(m_rd);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge SYS_CLK); n++; end
    checks++;
    if (!ok || cnt_rd !== CW'(m_rd)) begin
      errors++;
      $display("FAIL back_to_back: accepts=%0d spacing_ok=%0b cnt_rd=%0d required 6 1 %0d",
               acc.size(), ok, cnt_rd, m_rd);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic er; int wc, wa, lat; logic [NT-1:0] sa, sc, sr; logic [14:0] ra; logic st;
    req_valid = 1'b1; req_wr = 1'b1; req_table = 3'd2; req_col = 15'd1; req_row = 15'd9;
    req_wdata = 64'hCAFE;
    @(negedge SYS_CLK);
    req_valid = 1'b0;
    checks++;
    if (tab_wen !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: tab_wen=%0b required 1", tab_wen);
    end
    DETECT_RST = 1'b1;
    #1;
    checks++;
    if (tab_wen !== 1'b0 || resp_valid !== 1'b0 || tab_sel !== '0 || cnt_rd !== '0 || cnt_wr !== '0 || cnt_err !== '0) begin
      errors++;
      $display("FAIL rst_mid: wen=%0b rvalid=%0b sel=%b cnt=%0d/%0d/%0d required 0 0 0000 0/0/0",
               tab_wen, resp_valid, tab_sel, cnt_rd, cnt_wr, cnt_err);
    end
    @(negedge SYS_CLK);
    DETECT_RST = 1'b0;
    model_clear();
    @(negedge SYS_CLK);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release: req_ready=%0b required 1", req_ready);
    end
    m_rd = sat_inc(m_rd);
    run_txn(1'b0, 3'd2, 15'd1, 15'd9, 64'h0, 0, rd, er, wc, wa, lat, sa, sc, sr, ra, st);
    checks++;
    if (rd !== exp_mem[2][adr(15'd1, 15'd9)] || cnt_rd !== CW'(m_rd)) begin
      errors++;
      $display("FAIL rst_cut_write: rdata=%h cnt_rd=%0d required %h %0d",
               rd, cnt_rd, exp_mem[2][adr(15'd1, 15'd9)], m_rd);
    end
  endtask

  task automatic test_saturation();
    logic [63:0] rd, e_rd; logic er, e_er; int wc, wa, lat; logic [NT-1:0] sa, sc, sr;
    logic [14:0] ra; logic st;
    for (int i = 0; i < CMAX + 2; i++) begin
      model_txn(1'b0, 3'd3, 15'd0, 15'd1, 64'h0, e_rd, e_er);
      run_txn(1'b0, 3'd3, 15'd0, 15'd1, 64'h0, 0, rd, er, wc, wa, lat, sa, sc, sr, ra, st);
      if (i == CMAX - 1 || i == CMAX + 1) begin
        checks++;
        if (cnt_rd !== CW'(m_rd)) begin
          errors++;
          $display("FAIL saturation: after %0d reads cnt_rd=%0d required %0d", i + 1, cnt_rd, m_rd);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, e_rd, wd; logic er, e_er, wr; int wc, wa, lat, hold;
    logic [NT-1:0] sa, sc, sr; logic [14:0] ra, col, row; logic st; logic [TW-1:0] tbl;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); tbl = TW'($urandom_range(0, 7));
      col = 15'($urandom_range(0, 3)); row = 15'($urandom_range(0, 15));
      wd = {$urandom, $urandom}; hold = $urandom_range(0, 3);
      model_txn(wr, tbl, col, row, wd, e_rd, e_er);
      run_txn(wr, tbl, col, row, wd, hold, rd, er, wc, wa, lat, sa, sc, sr, ra, st);
      checks++;
      if (rd !== e_rd || er !== e_er || wc != ((wr && !e_er) ? 1 : 0) || lat != 3 || st !== 1'b1) begin
        errors++;
        $display("FAIL rand_%0d: rdata=%h err=%0b wen=%0d lat=%0d stable=%0b required %h %0b %0d 3 1",
                 i, rd, er, wc, lat, st, e_rd, e_er, (wr && !e_er) ? 1 : 0);
      end
      checks++;
      if (cnt_rd !== CW'(m_rd) || cnt_wr !== CW'(m_wr) || cnt_err !== CW'(m_err)) begin
        errors++;
        $display("FAIL rand_cnt_%0d: r/w/e=%0d/%0d/%0d required %0d/%0d/%0d",
                 i, cnt_rd, cnt_wr, cnt_err, m_rd, m_wr, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
